// File: rtl/cp0_regfile.sv
// CP0 register file and exception sequencer. Commits MTC0/SYSCALL/ERET from WB,
// takes hardware/timer interrupts, and drives the PC-redirect/flush request.
module cp0_regfile #(
  parameter logic [31:0] EXC_VEC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [2:0]  wr_cp0op,
  input  logic [4:0]  wr_rd,
  input  logic [31:0] wr_din,
  input  logic [31:0] wr_pc,
  input  logic [4:0]  rd_addr,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_dout,
  output logic        exc_req,
  output logic [31:0] exc_target
);

  localparam logic [2:0] OP_NONE    = 3'b000;
  localparam logic [2:0] OP_MFC0    = 3'b001;
  localparam logic [2:0] OP_MTC0    = 3'b010;
  localparam logic [2:0] OP_ERET    = 3'b011;
  localparam logic [2:0] OP_SYSCALL = 3'b100;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q,     epc_d;
  logic [5:0]  im_q,      im_d;
  logic        exl_q,     exl_d;
  logic        ie_q,      ie_d;
  logic [4:0]  exccode_q, exccode_d;
  logic        ti_q,      ti_d;

  logic [5:0]  ip;
  logic        is_sys, is_eret, is_mtc0;
  logic        int_take, mtc0_commit, compare_wr;
  logic [31:0] status_rd, cause_rd;
  logic [31:0] cur_val, byp_val;
  logic        rd_writable;

  // Event decode
  always_comb begin
    ip          = {hw_int[5] | ti_q, hw_int[4:0]};
    is_sys      = wr_valid && (wr_cp0op == OP_SYSCALL);
    is_eret     = wr_valid && (wr_cp0op == OP_ERET);
    is_mtc0     = wr_valid && (wr_cp0op == OP_MTC0);
    int_take    = wr_valid && ie_q && !exl_q && (|(ip & im_q));
    mtc0_commit = is_mtc0 && !int_take;
    compare_wr  = mtc0_commit && (wr_rd == REG_COMPARE);
  end

  // Redirect request; reset suppresses any event sitting in WB
  always_comb begin
    exc_req    = 1'b0;
    exc_target = EXC_VEC;
    if (!rst) begin
      if (int_take || is_sys) begin
        exc_req    = 1'b1;
        exc_target = EXC_VEC;
      end else if (is_eret) begin
        exc_req    = 1'b1;
        exc_target = epc_q;
      end
    end
  end

  // Next-state logic; events are mutually exclusive in priority order
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    epc_d     = epc_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    exccode_d = exccode_q;
    ti_d      = ti_q;

    if (int_take) begin
      epc_d     = wr_pc;
      exl_d     = 1'b1;
      exccode_d = EXC_INT;
    end else if (is_sys) begin
      epc_d     = wr_pc + 32'd4;
      exl_d     = 1'b1;
      exccode_d = EXC_SYS;
    end else if (is_eret) begin
      exl_d = 1'b0;
    end else if (mtc0_commit) begin
      case (wr_rd)
        REG_COUNT:   count_d   = wr_din;
        REG_COMPARE: compare_d = wr_din;
        REG_STATUS: begin
          im_d  = wr_din[15:10];
          exl_d = wr_din[1];
          ie_d  = wr_din[0];
        end
        REG_EPC:     epc_d     = wr_din;
        default:     ;
      endcase
    end

    // Timer match is against the post-increment (or written) count
    if (compare_wr)
      ti_d = 1'b0;
    else if (count_d == compare_q)
      ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      epc_q     <= 32'd0;
      im_q      <= 6'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      exccode_q <= 5'd0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      epc_q     <= epc_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      exccode_q <= exccode_d;
      ti_q      <= ti_d;
    end
  end

  // MFC0 read path with same-cycle MTC0 bypass
  always_comb begin
    status_rd = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_rd  = {16'd0, ip, 3'd0, exccode_q, 2'd0};

    cur_val     = 32'd0;
    byp_val     = 32'd0;
    rd_writable = 1'b0;
    case (rd_addr)
      REG_COUNT: begin
        cur_val     = count_q;
        byp_val     = wr_din;
        rd_writable = 1'b1;
      end
      REG_COMPARE: begin
        cur_val     = compare_q;
        byp_val     = wr_din;
        rd_writable = 1'b1;
      end
      REG_STATUS: begin
        cur_val     = status_rd;
        byp_val     = wr_din & 32'h0000_FC03;
        rd_writable = 1'b1;
      end
      REG_CAUSE:   cur_val = cause_rd;
      REG_EPC: begin
        cur_val     = epc_q;
        byp_val     = wr_din;
        rd_writable = 1'b1;
      end
      default:     ;
    endcase

    // Cause has no writable bits, so an MTC0 to it leaves the read unchanged
    if (mtc0_commit && (wr_rd == rd_addr) && rd_writable)
      cp0_dout = byp_val;
    else
      cp0_dout = cur_val;
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus random traffic,
// all checked against a register-array reference model.
module tb_cp0_regfile;

  localparam logic [31:0] VEC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [2:0]  wr_cp0op;
  logic [4:0]  wr_rd;
  logic [31:0] wr_din;
  logic [31:0] wr_pc;
  logic [4:0]  rd_addr;
  logic [5:0]  hw_int;
  logic [31:0] cp0_dout;
  logic        exc_req;
  logic [31:0] exc_target;

  int total = 0;
  int bad   = 0;

  cp0_regfile #(.EXC_VEC(VEC)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_cp0op(wr_cp0op),
    .wr_rd(wr_rd), .wr_din(wr_din), .wr_pc(wr_pc), .rd_addr(rd_addr),
    .hw_int(hw_int), .cp0_dout(cp0_dout), .exc_req(exc_req),
    .exc_target(exc_target)
  );

  always #5 clk = ~clk;

  // Reference model: registers held in an indexed array
  logic [31:0] m_reg [0:31];
  logic        m_ti;
  logic [4:0]  m_exc;

  function automatic logic [31:0] wmask(input logic [4:0] a);
    case (a)
      5'd9, 5'd11, 5'd14: return 32'hFFFF_FFFF;
      5'd12:              return 32'h0000_FC03;
      default:            return 32'h0;
    endcase
  endfunction

  function automatic logic [5:0] m_ip(input logic [5:0] hw);
    return {hw[5] | m_ti, hw[4:0]};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [5:0] hw);
    if (a == 5'd13) return (32'(m_ip(hw)) << 10) | (32'(m_exc) << 2);
    return m_reg[a] & wmask(a);
  endfunction

  function automatic bit m_irq();
    logic [31:0] st;
    st = m_reg[12];
    return wr_valid && st[0] && !st[1] && ((m_ip(hw_int) & st[15:10]) != 6'd0);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_reg[11] = 32'hFFFF_FFFF;
    m_ti  = 1'b0;
    m_exc = 5'd0;
  endtask

  task automatic m_clock();
    bit irq, cmp_wr;
    logic [31:0] nc;
    if (rst) begin
      m_reset();
      return;
    end
    irq    = m_irq();
    cmp_wr = 1'b0;
    nc     = m_reg[9] + 32'd1;
    if (irq) begin
      m_reg[14] = wr_pc; m_reg[12][1] = 1'b1; m_exc = 5'd0;
    end else if (wr_valid && wr_cp0op == 3'b100) begin
      m_reg[14] = wr_pc + 32'd4; m_reg[12][1] = 1'b1; m_exc = 5'd8;
    end else if (wr_valid && wr_cp0op == 3'b011) begin
      m_reg[12][1] = 1'b0;
    end else if (wr_valid && wr_cp0op == 3'b010) begin
      if (wr_rd == 5'd9) nc = wr_din;
      else if (wmask(wr_rd) != 32'h0) m_reg[wr_rd] = wr_din & wmask(wr_rd);
      cmp_wr = (wr_rd == 5'd11);
    end
    m_reg[9] = nc;
    if (cmp_wr) m_ti = 1'b0;
    else if (nc == m_reg[11]) m_ti = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, advance model at posedge.
  // lit_sel: 0 none, 1 literal cp0_dout, 2 literal exc_req, 3 literal exc_target
  task automatic cyc(input bit r, input bit v, input logic [2:0] op, input logic [4:0] rd,
                     input logic [31:0] din, input logic [31:0] pc, input logic [4:0] ra,
                     input logic [5:0] hw, input int lit_sel = 0, input logic [31:0] lit = 0);
    bit e_req, irq, mt;
    logic [31:0] e_tgt, e_dout;
    @(negedge clk);
    rst = r; wr_valid = v; wr_cp0op = op; wr_rd = rd; wr_din = din;
    wr_pc = pc; rd_addr = ra; hw_int = hw;
    #1;
    irq   = m_irq();
    e_req = 1'b0; e_tgt = 32'h0;
    if (!r) begin
      if (irq || (v && op == 3'b100)) begin e_req = 1'b1; e_tgt = VEC; end
      else if (v && op == 3'b011) begin e_req = 1'b1; e_tgt = m_reg[14]; end
    end
    mt = v && op == 3'b010 && !irq;
    if (mt && rd == ra && wmask(ra) != 32'h0) e_dout = din & wmask(ra);
    else e_dout = m_read(ra, hw);
    chk("exc_req", 32'(exc_req), 32'(e_req));
    if (e_req) chk("exc_target", exc_target, e_tgt);
    if (!r) chk("cp0_dout", cp0_dout, e_dout);
    case (lit_sel)
      1: chk("lit_dout", cp0_dout, lit);
      2: chk("lit_req", 32'(exc_req), lit);
      3: chk("lit_target", exc_target, lit);
      default: ;
    endcase
    @(posedge clk);
    m_clock();
  endtask

  task automatic idle(input logic [4:0] ra, input int lit_sel = 0, input logic [31:0] lit = 0);
    cyc(0, 0, 3'b000, 5'd0, 32'h0, 32'h0, ra, 6'd0, lit_sel, lit);
  endtask

  task automatic mtc0(input logic [4:0] rd, input logic [31:0] din, input logic [4:0] ra,
                      input int lit_sel = 0, input logic [31:0] lit = 0);
    cyc(0, 1, 3'b010, rd, din, 32'h0, ra, 6'd0, lit_sel, lit);
  endtask

  logic [4:0] regs [0:5];

  initial begin
    regs[0] = 5'd9; regs[1] = 5'd11; regs[2] = 5'd12;
    regs[3] = 5'd13; regs[4] = 5'd14; regs[5] = 5'd3;
    m_reset();

    cyc(1, 0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd12, 6'd0);
    cyc(1, 0, 3'b000, 5'd0, 32'h0, 32'h0, 5'd12, 6'd0);
    idle(5'd11, 1, 32'hFFFF_FFFF);
    idle(5'd12, 1, 32'h0);

    // Timer: Count=10 when Compare<-20 is written
    mtc0(5'd9, 32'd10, 5'd9);
    mtc0(5'd11, 32'd20, 5'd9, 1, 32'd10);
    for (int i = 0; i < 8; i++) idle(5'd13);
    idle(5'd13, 1, 32'h0);
    idle(5'd13, 1, 32'h0000_8000);
    idle(5'd13, 2, 32'h0);
    mtc0(5'd11, 32'd50, 5'd13);
    idle(5'd13, 1, 32'h0);
    mtc0(5'd11, 32'hFFFF_FFFF, 5'd11);

    // Status write with bypass
    mtc0(5'd12, 32'h0000_FC01, 5'd12, 1, 32'h0000_FC01);
    idle(5'd12, 1, 32'h0000_FC01);

    // SYSCALL then ERET
    cyc(0, 1, 3'b100, 5'd0, 32'h0, 32'h0000_0100, 5'd14, 6'd0, 3, VEC);
    idle(5'd14, 1, 32'h0000_0104);
    idle(5'd12, 1, 32'h0000_FC03);
    idle(5'd13, 1, 32'h0000_0020);
    cyc(0, 1, 3'b011, 5'd0, 32'h0, 32'h0000_0300, 5'd12, 6'd0, 3, 32'h0000_0104);
    idle(5'd12, 1, 32'h0000_FC01);

    // Interrupt aborts the MTC0 in WB
    mtc0(5'd12, 32'h0000_0401, 5'd12);
    cyc(0, 1, 3'b010, 5'd14, 32'd5, 32'h0000_0200, 5'd14, 6'b000001, 2, 32'd1);
    idle(5'd14, 1, 32'h0000_0200);
    idle(5'd13, 1, 32'h0);
    cyc(0, 1, 3'b000, 5'd0, 32'h0, 32'h0000_0204, 5'd12, 6'b000001, 2, 32'd0);
    cyc(0, 1, 3'b011, 5'd0, 32'h0, 32'h0000_0208, 5'd12, 6'd0, 3, 32'h0000_0200);

    // Reset during SYSCALL in WB
    cyc(1, 1, 3'b100, 5'd0, 32'h0, 32'h0000_0400, 5'd14, 6'd0, 2, 32'd0);
    idle(5'd14, 1, 32'h0);
    idle(5'd12, 1, 32'h0);
    idle(5'd11, 1, 32'hFFFF_FFFF);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit r, v;
      logic [2:0]  op;
      logic [4:0]  rd, ra;
      logic [31:0] din;
      logic [5:0]  hw;
      r   = ($urandom_range(0, 63) == 0);
      v   = ($urandom_range(0, 3) != 0);
      op  = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 1) == 0) op = 3'b010;
      rd  = regs[$urandom_range(0, 5)];
      ra  = ($urandom_range(0, 2) == 0) ? rd : regs[$urandom_range(0, 5)];
      din = $urandom;
      if (rd == 5'd9)  din = m_reg[11] - 32'($urandom_range(1, 6));
      if (rd == 5'd11) din = m_reg[9] + 32'($urandom_range(1, 6));
      if (rd == 5'd12 && $urandom_range(0, 1) == 0) din = din & 32'hFFFF_FFFD;
      hw  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'd0;
      cyc(r, v, op, rd, din, $urandom & 32'hFFFF_FFFC, ra, hw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
